// File: rtl/difficulty_select_ctrl_pkg.sv
// Shared difficulty encodings, menu FSM states and 50 MHz timing defaults.
// Pure declarations: no latency and no flow control.
package difficulty_select_ctrl_pkg;

  localparam logic [1:0] DIFF_EASY = 2'b00;
  localparam logic [1:0] DIFF_HARD = 2'b01;
  localparam logic [1:0] DIFF_HELL = 2'b10;

  typedef enum logic [1:0] {
    SELECT = 2'b00,
    FLASH  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_BLINK_HALF      = 12500000;
  localparam int DEF_FLASH_COUNT     = 3;

  // Unknown codes fall back to EASY so the 11 encoding can never persist.
  function automatic logic [1:0] diff_next(input logic [1:0] d);
    case (d)
      DIFF_EASY: diff_next = DIFF_HARD;
      DIFF_HARD: diff_next = DIFF_HELL;
      default:   diff_next = DIFF_EASY;
    endcase
  endfunction

  function automatic logic [1:0] diff_prev(input logic [1:0] d);
    case (d)
      DIFF_EASY: diff_prev = DIFF_HELL;
      DIFF_HELL: diff_prev = DIFF_HARD;
      default:   diff_prev = DIFF_EASY;
    endcase
  endfunction

  function automatic int flash_half(input int blink_half);
    flash_half = (blink_half / 4 < 1) ? 1 : blink_half / 4;
  endfunction

  function automatic int cnt_width(input int max_count);
    cnt_width = (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/difficulty_select_ctrl_btn_debounce.sv
// Push-button synchroniser and debouncer with a one-cycle rising-edge press pulse.
// Press lands 2 sync cycles + DEBOUNCE_CYCLES after a clean edge; no backpressure.
module btn_debounce
  import difficulty_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The count only runs while the synchronised level disagrees with the
  // accepted one, so any bounce back to the old level restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/difficulty_select_ctrl.sv
// Difficulty menu: debounced step/confirm buttons, blinking selection, confirm flash, lock and start pulse.
// Outputs registered one clock after the internal event; buttons are dropped outside SELECT.
module difficulty_select_ctrl
  import difficulty_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_HALF      = DEF_BLINK_HALF,
  parameter int FLASH_COUNT     = DEF_FLASH_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_confirm,
  input  logic       game_over,
  output logic [1:0] difficulty,
  output logic       display_on,
  output logic       diff_locked,
  output logic       game_start
);

  localparam int FLASH_HALF = flash_half(BLINK_HALF);
  localparam int TW         = cnt_width(BLINK_HALF);
  localparam int SW         = cnt_width(2 * FLASH_COUNT);

  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_HALF - 1);
  localparam logic [SW-1:0] SEG_LAST   = SW'(2 * FLASH_COUNT - 1);

  logic next_evt;
  logic prev_evt;
  logic confirm_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .press (next_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_prev),
    .press (prev_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_confirm),
    .press (confirm_evt)
  );

  state_e        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SELECT;
      timer       <= '0;
      seg         <= '0;
      difficulty  <= DIFF_EASY;
      display_on  <= 1'b1;
      diff_locked <= 1'b0;
      game_start  <= 1'b0;
    end else begin
      game_start <= 1'b0;
      case (state)
        SELECT: begin
          if (confirm_evt) begin
            state      <= FLASH;
            timer      <= '0;
            seg        <= '0;
            display_on <= 1'b0;
          end else if (next_evt != prev_evt) begin
            difficulty <= next_evt ? diff_next(difficulty) : diff_prev(difficulty);
            timer      <= '0;
            display_on <= 1'b1;
          end else if (timer == BLINK_LAST) begin
            timer      <= '0;
            display_on <= ~display_on;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Entry already made the first toggle (1->0); each segment boundary
        // toggles again, and the final boundary hands over to LOCKED lit.
        FLASH: begin
          if (timer == FLASH_LAST) begin
            timer <= '0;
            if (seg == SEG_LAST) begin
              state       <= LOCKED;
              display_on  <= 1'b1;
              diff_locked <= 1'b1;
              game_start  <= 1'b1;
            end else begin
              seg        <= seg + 1'b1;
              display_on <= ~display_on;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        LOCKED: begin
          display_on <= 1'b1;
          if (game_over) begin
            state       <= SELECT;
            timer       <= '0;
            diff_locked <= 1'b0;
          end
        end

        default: begin
          state       <= SELECT;
          timer       <= '0;
          display_on  <= 1'b1;
          diff_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/difficulty_select_ctrl.md
Name: difficulty_select_ctrl

Overview:
Menu controller that lets the player choose the game difficulty from push-buttons before play starts, and drives the 2-bit difficulty code into the four-digit EASY/HARD/HELL display.
- Debounces the buttons, steps and wraps the selection, and blinks the display while the choice is open.
- Flashes to confirm the choice, then locks it and pulses game start.
- Sits between the board keys, the difficulty display and the game core; re-opens the menu on game over.

Parameters:
DEBOUNCE_CYCLES, 50000, clock cycles a synchronised button level must be stable before it is accepted (1 ms at 50 MHz).
BLINK_HALF, 12500000, clock cycles per half-period of the selection blink (0.25 s at 50 MHz).
FLASH_COUNT, 3, number of off/on flashes shown after confirm.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
btn_next  input  1  async, active-high: step to the next difficulty (already inverted from KEY).
btn_prev  input  1  async, active-high: step to the previous difficulty.
btn_confirm  input  1  async, active-high: confirm the current difficulty.
game_over  input  1  one-cycle pulse from the game core; re-opens the menu.
difficulty  output  2  selected code: 00 EASY, 01 HARD, 10 HELL. Never drives 11.
display_on  output  1  1 = show the difficulty digits; 0 = top level blanks HEX0-3.
diff_locked  output  1  1 while a difficulty is locked for play.
game_start  output  1  one-cycle pulse when the lock takes effect.

Behaviour:
- Reset (synchronous, highest priority), all registers cleared in the reset cycle:
  - state = SELECT, difficulty = 00, display_on = 1, diff_locked = 0, game_start = 0.
  - All counters, synchronisers and debounced levels = 0.
  - Reset asserted mid-FLASH or mid-LOCKED returns to these values, with no game_start pulse.
- Button path, per button:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level updates only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a single-cycle pulse on the debounced rising edge.
  - Release creates no event. Holding a button produces exactly one event.
- SELECT state:
  - display_on toggles every BLINK_HALF cycles, starting from 1.
  - next event: difficulty 00->01->10->00. prev event: 00->10->01->00.
  - Any step resets the blink counter and forces display_on = 1 on the following cycle.
  - next and prev events in the same cycle: no change.
  - confirm event: go to FLASH next cycle. Confirm takes priority over a same-cycle next/prev, which is discarded.
  - game_over is ignored in SELECT.
- FLASH state:
  - Buttons and game_over are ignored; difficulty is frozen.
  - display_on starts at 0 and toggles every BLINK_HALF/4 cycles (integer division, minimum 1) for 2*FLASH_COUNT toggles, ending at 1.
  - Then go to LOCKED.
- LOCKED state:
  - On the entry cycle: diff_locked = 1 and game_start = 1 for exactly that one cycle.
  - display_on = 1 steady; all button events are ignored.
  - game_over pulse: back to SELECT next cycle with diff_locked = 0. difficulty is retained, and the blink restarts at display_on = 1.
- Outputs are registered: the output change lands on the clock after the event.
- Counter widths come from $clog2 of the parameters. Counters saturate or reload; they never wrap into false events.

Decomposition:
- Shared game package holds:
  - difficulty encodings DIFF_EASY=2'b00, DIFF_HARD=2'b01, DIFF_HELL=2'b10;
  - FSM state encodings SELECT/FLASH/LOCKED;
  - default timing constants at 50 MHz.
- One sub-module, btn_debounce: synchroniser, stability counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated three times.
- The FSM, the difficulty step logic and the blink timer live in difficulty_select_ctrl.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4, BLINK_HALF=8, FLASH_COUNT=2.
- Reset, then idle for 40 cycles -> difficulty=00, diff_locked=0, game_start=0; display_on toggles every 8 cycles, starting at 1.
- Press btn_next cleanly three times, each held 10 cycles -> difficulty 01, 10, 00, each 1 cycle after its debounce completes. Then one btn_prev -> 10.
- btn_next toggling every 2 cycles for 20 cycles, then low -> no difficulty change. A 3-cycle pulse -> no change. A 5-cycle pulse -> exactly one step.
- Select 01, then btn_confirm -> FLASH. display_on is 0,1,0,1 in 2-cycle segments. Then LOCKED: game_start high exactly 1 cycle, diff_locked=1, difficulty=01 held while next/prev are pressed.
- In LOCKED, pulse game_over -> SELECT next cycle, diff_locked=0, difficulty=01, display_on=1. game_over pulsed while in SELECT -> no effect.
- next and confirm debounced in the same cycle -> difficulty unchanged, FLASH entered. Assert reset mid-FLASH -> all outputs at reset values the next cycle, no game_start.
